// File: rtl/rf_write_arbiter.sv
// Single write port driver for the 3R/1W register file: arbitrates pipeline writeback
// against buffered MDU results, registers the winner and exposes it for forwarding.
module rf_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_wa,
    input  logic [31:0] mdu_wd,
    output logic        mdu_ready,
    output logic        stall_req,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    input  logic [4:0]  fwd_ra1,
    input  logic [4:0]  fwd_ra2,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX - 1);

    logic [4:0]       fifo_wa_q [DEPTH];
    logic [31:0]      fifo_wd_q [DEPTH];
    logic [DEPTH-1:0] fifo_live_q;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          we_q, we_d;
    logic [4:0]    wa_q, wa_d;
    logic [31:0]   wd_q, wd_d;

    logic pipe_req, fifo_empty, push, pop, head_write;

    assign pipe_req   = pipe_we && (pipe_wa != 5'd0);
    assign fifo_empty = (count_q == '0);
    // Ready looks only at the registered count, so a full FIFO refuses even while popping.
    assign mdu_ready  = !rst && (count_q != FULL_CNT);
    assign push       = mdu_valid && mdu_ready;
    assign pop        = !pipe_req && !fifo_empty;
    assign head_write = fifo_live_q[rd_ptr_q] && (fifo_wa_q[rd_ptr_q] != 5'd0);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        we_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = '0;
        stall_d  = 1'b0;

        if (pipe_req) begin
            we_d = 1'b1;
            wa_d = pipe_wa;
            wd_d = pipe_wd;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (head_write) begin
                we_d = 1'b1;
                wa_d = fifo_wa_q[rd_ptr_q];
                wd_d = fifo_wd_q[rd_ptr_q];
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // Counter saturates so a violated stall keeps being requested until the head drains.
        if (!fifo_empty && !pop) begin
            stall_d  = (starve_q == STARVE_TOP);
            starve_d = stall_d ? starve_q : starve_q + SW'(1);
        end
    end

    // NOTE: FIFO storage is not reset; count/pointers define which slots are meaningful.
    always_ff @(posedge clk) begin
        if (pipe_req) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_wa_q[i] == pipe_wa) fifo_live_q[i] <= 1'b0;
            end
        end
        if (push) begin
            fifo_wa_q[wr_ptr_q]   <= mdu_wa;
            fifo_wd_q[wr_ptr_q]   <= mdu_wd;
            fifo_live_q[wr_ptr_q] <= 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            wa_q     <= 5'd0;
            wd_q     <= 32'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    assign stall_req = stall_q;
    assign we        = we_q;
    assign wa        = wa_q;
    assign wd        = wd_q;
    assign fwd_data  = wd_q;
    assign fwd_hit1  = we_q && (wa_q != 5'd0) && (fwd_ra1 == wa_q);
    assign fwd_hit2  = we_q && (wa_q != 5'd0) && (fwd_ra2 == wa_q);
endmodule
